// File: rtl/display_bcd_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : display_bcd_encoder                                          |
// | Description : Converts a 14-bit binary value to four 7-segment digit       |
// |               patterns using a sequential shift-add-3 (double dabble)      |
// |               conversion followed by one encode cycle. Values above 9999   |
// |               show "----" and raise overflow.                              |
// |               Optional macro DISPLAY_BCD_BLANK_EN blanks leading zeros.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module display_bcd_encoder #(
    parameter int DP_DIGIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] value,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [7:0]  segment1,
    output logic [7:0]  segment2,
    output logic [7:0]  segment3,
    output logic [7:0]  segment4
);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_CONVERT = 2'd1;
    localparam logic [1:0]  c_ENCODE  = 2'd2;

    localparam logic [3:0]  c_BITS    = 4'd14;
    localparam logic [13:0] c_MAX     = 14'd9999;

    // Bit i lights the decimal point of digit i (index 0 = segment1, leftmost)
    localparam logic [3:0]  c_DP_MASK = {(DP_DIGIT == 4), (DP_DIGIT == 3),
                                         (DP_DIGIT == 2), (DP_DIGIT == 1)};

    localparam logic [6:0]  c_DASH    = 7'h40;

    logic [1:0]  r_state;
    logic [13:0] r_shift;
    logic [15:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_ovf_cap;

    logic [15:0] w_bcd_adj;
    logic [15:0] w_bcd_next;
    logic [2:0]  w_blank;
    logic [7:0]  w_seg [4];

    // Digit to segment pattern, bit0=a .. bit6=g
    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next value MSB
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
        w_bcd_next = {w_bcd_adj[14:0], r_shift[13]};
    end

    // Segment patterns for the finished BCD result (thousands first)
    always_comb begin
        w_blank[0] = (r_bcd[15:12] == 4'd0);
        w_blank[1] = w_blank[0] && (r_bcd[11:8] == 4'd0);
        w_blank[2] = w_blank[1] && (r_bcd[7:4] == 4'd0);
        for (int i = 0; i < 4; i++) begin
            if (r_ovf_cap) begin
                w_seg[i] = {c_DP_MASK[i], c_DASH};
            end else begin
                w_seg[i] = {c_DP_MASK[i], f_seg(r_bcd[(3-i)*4 +: 4])};
`ifdef DISPLAY_BCD_BLANK_EN
                // Units digit is never blanked so zero still shows as "0"
                if (i < 3 && w_blank[i]) begin
                    w_seg[i][6:0] = 7'h00;
                end
`endif
            end
        end
    end

    // Control FSM with registered status and segment outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_shift   <= 14'd0;
            r_bcd     <= 16'd0;
            r_cnt     <= 4'd0;
            r_ovf_cap <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            segment1  <= 8'h00;
            segment2  <= 8'h00;
            segment3  <= 8'h00;
            segment4  <= 8'h00;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_shift   <= value;
                        r_bcd     <= 16'd0;
                        r_cnt     <= c_BITS;
                        r_ovf_cap <= (value > c_MAX);
                        busy      <= 1'b1;
                        r_state   <= c_CONVERT;
                    end
                end
                c_CONVERT: begin
                    r_bcd   <= w_bcd_next;
                    r_shift <= {r_shift[12:0], 1'b0};
                    r_cnt   <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= c_ENCODE;
                    end
                end
                c_ENCODE: begin
                    segment1 <= w_seg[0];
                    segment2 <= w_seg[1];
                    segment3 <= w_seg[2];
                    segment4 <= w_seg[3];
                    overflow <= r_ovf_cap;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= c_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_bcd_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_display_bcd_encoder                                       |
// | Description : Self-checking bench for display_bcd_encoder. Two instances   |
// |               (DP_DIGIT=0 and DP_DIGIT=2) share stimulus and are compared  |
// |               every cycle against a cycle-level arithmetic model, plus     |
// |               hand-computed literal expectations.                          |
// |               Honours macro DISPLAY_BCD_BLANK_EN.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_display_bcd_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] value;

    logic        busy0, done0, ovf0;
    logic [7:0]  a1, a2, a3, a4;
    logic        busy2, done2, ovf2;
    logic [7:0]  b1, b2, b3, b4;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    display_bcd_encoder #(.DP_DIGIT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy0), .done(done0), .overflow(ovf0),
        .segment1(a1), .segment2(a2), .segment3(a3), .segment4(a4)
    );

    display_bcd_encoder #(.DP_DIGIT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy2), .done(done2), .overflow(ovf2),
        .segment1(b1), .segment2(b2), .segment3(b3), .segment4(b4)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic logic [7:0] pat_of(input int d);
        case (d)
            0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
            4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
            8: return 8'h7F;  9: return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    // Expected pattern for display position pos (1 = thousands .. 4 = units)
    function automatic logic [7:0] model_seg(input int cap, input int dp, input int pos);
        logic [7:0] s;
        int pw;
        pw = (pos == 1) ? 1000 : (pos == 2) ? 100 : (pos == 3) ? 10 : 1;
        if (cap > 9999) begin
            s = 8'h40;
        end else begin
            s = pat_of((cap / pw) % 10);
`ifdef DISPLAY_BCD_BLANK_EN
            if (pos != 4 && cap < pw) s = 8'h00;
`endif
        end
        if (dp == pos) s[7] = 1'b1;
        return s;
    endfunction

    int m_phase = 0;      // 0 idle, k = k-th cycle since the start was accepted
    int m_cap   = 0;
    int m_shown = -1;     // value on display, -1 = reset (all dark)
    bit m_done  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_shown = -1;
            m_done  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_phase == 0) begin
                if (start) begin
                    m_cap   = int'(value);
                    m_phase = 1;
                end
            end else if (m_phase == 15) begin
                m_phase = 0;
                m_done  = 1'b1;
                m_shown = m_cap;
            end else begin
                m_phase = m_phase + 1;
            end
        end
    end

    function automatic logic [7:0] exp_seg(input int dp, input int pos);
        return (m_shown < 0) ? 8'h00 : model_seg(m_shown, dp, pos);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("busy0", {31'd0, busy0}, {31'd0, m_phase != 0});
            chk("done0", {31'd0, done0}, {31'd0, m_done});
            chk("ovf0",  {31'd0, ovf0},  {31'd0, m_shown > 9999});
            chk("seg0_1", {24'd0, a1}, {24'd0, exp_seg(0, 1)});
            chk("seg0_2", {24'd0, a2}, {24'd0, exp_seg(0, 2)});
            chk("seg0_3", {24'd0, a3}, {24'd0, exp_seg(0, 3)});
            chk("seg0_4", {24'd0, a4}, {24'd0, exp_seg(0, 4)});
            chk("busy2", {31'd0, busy2}, {31'd0, m_phase != 0});
            chk("done2", {31'd0, done2}, {31'd0, m_done});
            chk("ovf2",  {31'd0, ovf2},  {31'd0, m_shown > 9999});
            chk("seg2_1", {24'd0, b1}, {24'd0, exp_seg(2, 1)});
            chk("seg2_2", {24'd0, b2}, {24'd0, exp_seg(2, 2)});
            chk("seg2_3", {24'd0, b3}, {24'd0, exp_seg(2, 3)});
            chk("seg2_4", {24'd0, b4}, {24'd0, exp_seg(2, 4)});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a conversion in the current cycle (cycle 0); return in the done cycle
    task automatic run_conv(input logic [13:0] v, output int lat);
        start = 1'b1;
        value = v;
        lat   = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (done0 && lat < 0) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic chk_segs0(input string name, input logic [31:0] exp);
        chk(name, {a1, a2, a3, a4}, exp);
    endtask

    task automatic chk_segs2(input string name, input logic [31:0] exp);
        chk(name, {b1, b2, b3, b4}, exp);
    endtask

    initial begin
        int lat;
        int ndone;
        int d1;
        int d2;
        rst   = 1'b1;
        start = 1'b0;
        value = 14'd0;
        tick(); tick(); tick();
        rst = 1'b0;
        check_en = 1'b1;

        // Reset state
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_ovf",  {31'd0, ovf0},  32'd0);
        chk_segs0("rst_segs", 32'h00000000);

        // 1234: latency and patterns
        run_conv(14'd1234, lat);
        chk("lat_1234", lat, 32'd16);
        chk_segs0("segs_1234", 32'h065B4F66);
        chk_segs2("dp_1234", 32'h06DB4F66);
        chk("ovf_1234", {31'd0, ovf0}, 32'd0);
        tick();

        // 7: leading zeros
        run_conv(14'd7, lat);
`ifdef DISPLAY_BCD_BLANK_EN
        chk_segs0("segs_7", 32'h00000007);
`else
        chk_segs0("segs_7", 32'h3F3F3F07);
`endif
        tick();

        // 10000 overflow, then 9999
        run_conv(14'd10000, lat);
        chk("lat_10000", lat, 32'd16);
        chk("ovf_10000", {31'd0, ovf0}, 32'd1);
        chk_segs0("segs_10000", 32'h40404040);
        chk_segs2("dp_10000", 32'h40C04040);
        tick();
        run_conv(14'd9999, lat);
        chk("ovf_9999", {31'd0, ovf0}, 32'd0);
        chk_segs0("segs_9999", 32'h6F6F6F6F);
        tick();

        // 16383 (max input) also overflows
        run_conv(14'd16383, lat);
        chk_segs0("segs_16383", 32'h40404040);
        tick();

        // 0 with DP on digit 2
        run_conv(14'd0, lat);
`ifdef DISPLAY_BCD_BLANK_EN
        chk_segs2("dp_0", 32'h0080003F);
`else
        chk_segs2("dp_0", 32'h3FBF3F3F);
`endif
        tick();

        // Starts while busy / in ENCODE ignored; start after done accepted
        start = 1'b1;
        value = 14'd4321;
        ndone = 0;
        d1 = -1;
        d2 = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start = (c == 5 || c == 15 || c == 17) ? 1'b1 : 1'b0;
            if (c == 5) value = 14'd55;
            if (done0) begin
                ndone++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
        end
        chk("ndone_b2b", ndone, 32'd2);
        chk("done1_cyc", d1, 32'd16);
        chk("done2_cyc", d2, 32'd33);

        // Reset mid-conversion aborts with no done
        start = 1'b1;
        value = 14'd8888;
        ndone = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start = 1'b0;
            rst   = (c == 8) ? 1'b1 : 1'b0;
            if (c == 9) begin
                chk("abort_busy", {31'd0, busy0}, 32'd0);
                chk_segs0("abort_segs", 32'h00000000);
            end
            if (c >= 9 && done0) ndone++;
        end
        chk("abort_ndone", ndone, 32'd0);

        // Reset wins over start in the same cycle
        rst   = 1'b1;
        start = 1'b1;
        value = 14'd42;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("rst_prio_busy", {31'd0, busy0}, 32'd0);
        tick(); tick();

        // Back-to-back after the priority check still works
        run_conv(14'd305, lat);
        chk("lat_305", lat, 32'd16);
        tick(); tick();

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
